// File: rtl/ex_stage_pkg.sv
// Shared definitions for the WISC execute stage.
// Contains opcode, branch-condition and forwarding-select encodings, the
// flag bit indices of the {Z,V,N} register, and saturation helpers used by
// the ALU.
package ex_stage_pkg;

    localparam int DW = 16;
    localparam int RW = 4;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] CCC_NE  = 3'b000;
    localparam logic [2:0] CCC_EQ  = 3'b001;
    localparam logic [2:0] CCC_GT  = 3'b010;
    localparam logic [2:0] CCC_LT  = 3'b011;
    localparam logic [2:0] CCC_GTE = 3'b100;
    localparam logic [2:0] CCC_LTE = 3'b101;
    localparam logic [2:0] CCC_OV  = 3'b110;
    localparam logic [2:0] CCC_UN  = 3'b111;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Saturate a 17-bit signed sum/difference to 16 bits.
    // Returns {overflow, saturated_result}.
    function automatic logic [16:0] sat16(input logic [16:0] s);
        if (s[16] != s[15])
            return {1'b1, (s[16] ? 16'h8000 : 16'h7FFF)};
        else
            return {1'b0, s[15:0]};
    endfunction

    // Signed 4-bit saturating add (+7 / -8).
    function automatic logic [3:0] sat_add4(input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        s = {x[3], x} + {y[3], y};
        if (s[4] != s[3])
            return s[4] ? 4'h8 : 4'h7;
        else
            return s[3:0];
    endfunction

endpackage

// File: rtl/ex_stage_alu16.sv
// alu16: purely combinational 16-bit WISC ALU.
// Ports:
//   opcode  in  4   effective opcode (LLB/LHB already resolved by caller)
//   a, b    in  16  forwarded operands
//   imm     in  16  sign-extended immediate (shift amount in imm[3:0])
//   result  out 16  ALU result / memory address
//   z, v, n out 1   flag values computed from this result
//   set_zvn out 1   instruction writes Z, V and N
//   set_z   out 1   instruction writes Z only
module alu16
    import ex_stage_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] imm,
    output logic [15:0] result,
    output logic        z,
    output logic        v,
    output logic        n,
    output logic        set_zvn,
    output logic        set_z
);

    logic [16:0] add_sat;
    logic [16:0] sub_sat;
    logic [8:0]  red_hi;
    logic [8:0]  red_lo;
    logic [3:0]  sh;
    logic [31:0] rot;
    logic [15:0] imm_x2;

    assign add_sat = sat16({a[15], a} + {b[15], b});
    assign sub_sat = sat16({a[15], a} - {b[15], b});
    // Byte sums are kept at 9 bits so they cannot overflow before the final add.
    assign red_hi  = {a[15], a[15:8]} + {b[15], b[15:8]};
    assign red_lo  = {a[7], a[7:0]} + {b[7], b[7:0]};
    assign sh      = imm[3:0];
    // Rotating the doubled word right means amount 0 leaves a unchanged.
    assign rot     = {a, a} >> sh;
    assign imm_x2  = {imm[14:0], 1'b0};

    always_comb begin
        result  = 16'h0000;
        v       = 1'b0;
        set_zvn = 1'b0;
        set_z   = 1'b0;
        case (opcode)
            OP_ADD: begin
                result  = add_sat[15:0];
                v       = add_sat[16];
                set_zvn = 1'b1;
            end
            OP_SUB: begin
                result  = sub_sat[15:0];
                v       = sub_sat[16];
                set_zvn = 1'b1;
            end
            OP_XOR: begin
                result = a ^ b;
                set_z  = 1'b1;
            end
            OP_RED:  result = {{7{red_hi[8]}}, red_hi} + {{7{red_lo[8]}}, red_lo};
            OP_SLL: begin
                result = a << sh;
                set_z  = 1'b1;
            end
            OP_SRA: begin
                result = $signed(a) >>> sh;
                set_z  = 1'b1;
            end
            OP_ROR: begin
                result = rot[15:0];
                set_z  = 1'b1;
            end
            OP_PADDSB: result = {sat_add4(a[15:12], b[15:12]), sat_add4(a[11:8], b[11:8]),
                                 sat_add4(a[7:4], b[7:4]), sat_add4(a[3:0], b[3:0])};
            OP_LW, OP_SW: result = (a & 16'hFFFE) + imm_x2;
            OP_LLB:  result = (a & 16'hFF00) | {8'h00, imm[7:0]};
            OP_LHB:  result = (a & 16'h00FF) | {imm[7:0], 8'h00};
            default: result = 16'h0000;
        endcase
    end

    assign z = (result == 16'h0000);
    assign n = result[15];

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage WISC pipeline.
// Applies operand forwarding, runs the ALU, owns the {Z,V,N} flag register,
// resolves branches combinationally and registers the EX/MEM latch.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en, flush                advance / bubble control for EX/MEM and flags
//   valid_in, opcode_in, ccc_in, *_in control, wreg_in, npc_in, a_in, b_in, imm_in
//                            ID/EX latch contents
//   fwd_a_sel, fwd_b_sel     00/11 ID/EX, 01 EX/MEM, 10 MEM/WB
//   exmem_fwd, memwb_fwd     forwarded results
//   br_taken, br_target      combinational branch resolution
//   flags_out                registered {Z,V,N}
//   *_out                    registered EX/MEM latch
//
// Pipeline control: each rising edge applies, in priority order,
// rst (clear everything), flush (insert a bubble: control/valid/wreg/data 0,
// flags held), !en (hold every register), otherwise capture. Flags change only
// on a captured cycle carrying a valid instruction.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          valid_in,
    input  logic [3:0]    opcode_in,
    input  logic [2:0]    ccc_in,
    input  logic          RegWrite_in,
    input  logic          MemRead_in,
    input  logic          MemWrite_in,
    input  logic          MemtoReg_in,
    input  logic          Lower_in,
    input  logic          Higher_in,
    input  logic          BEn_in,
    input  logic          Br_in,
    input  logic          PCS_in,
    input  logic [RW-1:0] wreg_in,
    input  logic [DW-1:0] npc_in,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic [DW-1:0] imm_in,
    input  logic [1:0]    fwd_a_sel,
    input  logic [1:0]    fwd_b_sel,
    input  logic [DW-1:0] exmem_fwd,
    input  logic [DW-1:0] memwb_fwd,
    output logic          br_taken,
    output logic [DW-1:0] br_target,
    output logic [2:0]    flags_out,
    output logic          RegWrite_out,
    output logic          MemRead_out,
    output logic          MemWrite_out,
    output logic          MemtoReg_out,
    output logic          valid_out,
    output logic [RW-1:0] wreg_out,
    output logic [DW-1:0] result_out,
    output logic [DW-1:0] store_out
);

    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          alu_z, alu_v, alu_n;
    logic          alu_set_zvn, alu_set_z;
    logic [DW-1:0] result_d;
    logic          cond;
    logic          fz, fv, fn;
    logic          capture;

    always_comb begin
        case (fwd_a_sel)
            FWD_EXMEM: fwd_a = exmem_fwd;
            FWD_MEMWB: fwd_a = memwb_fwd;
            default:   fwd_a = a_in;
        endcase
        case (fwd_b_sel)
            FWD_EXMEM: fwd_b = exmem_fwd;
            FWD_MEMWB: fwd_b = memwb_fwd;
            default:   fwd_b = b_in;
        endcase
    end

    // Decode marks byte loads explicitly; those flags pick the LLB/LHB datapath.
    always_comb begin
        if (Lower_in)
            alu_op = OP_LLB;
        else if (Higher_in)
            alu_op = OP_LHB;
        else
            alu_op = opcode_in;
    end

    alu16 u_alu (
        .opcode  (alu_op),
        .a       (fwd_a),
        .b       (fwd_b),
        .imm     (imm_in),
        .result  (alu_result),
        .z       (alu_z),
        .v       (alu_v),
        .n       (alu_n),
        .set_zvn (alu_set_zvn),
        .set_z   (alu_set_z)
    );

    assign result_d = PCS_in ? npc_in : alu_result;

    // Branches test the flags left by the previous instruction.
    assign fz = flags_out[FLAG_Z];
    assign fv = flags_out[FLAG_V];
    assign fn = flags_out[FLAG_N];

    always_comb begin
        case (ccc_in)
            CCC_NE:  cond = !fz;
            CCC_EQ:  cond = fz;
            CCC_GT:  cond = !fz && !fn;
            CCC_LT:  cond = fn;
            CCC_GTE: cond = fz || !fn;
            CCC_LTE: cond = fn || fz;
            CCC_OV:  cond = fv;
            default: cond = 1'b1;
        endcase
    end

    assign br_taken  = !rst && valid_in && BEn_in && cond;
    assign br_target = Br_in ? fwd_a : npc_in + {imm_in[DW-2:0], 1'b0};

    assign capture = en && !flush && valid_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_out <= 3'b000;
        end else if (capture) begin
            if (alu_set_zvn) begin
                flags_out <= {alu_z, alu_v, alu_n};
            end else if (alu_set_z) begin
                flags_out[FLAG_Z] <= alu_z;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            RegWrite_out <= 1'b0;
            MemRead_out  <= 1'b0;
            MemWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            valid_out    <= 1'b0;
            wreg_out     <= '0;
            result_out   <= '0;
            store_out    <= '0;
        end else if (en) begin
            // Control bits of a non-instruction are squashed so it cannot write state.
            RegWrite_out <= RegWrite_in && valid_in;
            MemRead_out  <= MemRead_in && valid_in;
            MemWrite_out <= MemWrite_in && valid_in;
            MemtoReg_out <= MemtoReg_in && valid_in;
            valid_out    <= valid_in;
            wreg_out     <= wreg_in;
            result_out   <= result_d;
            store_out    <= fwd_b;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst, en, flush, valid_in;
    logic [3:0]  opcode_in;
    logic [2:0]  ccc_in;
    logic        RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in;
    logic        Lower_in, Higher_in, BEn_in, Br_in, PCS_in;
    logic [3:0]  wreg_in;
    logic [15:0] npc_in, a_in, b_in, imm_in;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] exmem_fwd, memwb_fwd;
    logic        br_taken;
    logic [15:0] br_target;
    logic [2:0]  flags_out;
    logic        RegWrite_out, MemRead_out, MemWrite_out, MemtoReg_out, valid_out;
    logic [3:0]  wreg_out;
    logic [15:0] result_out, store_out;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
        .opcode_in(opcode_in), .ccc_in(ccc_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemtoReg_in(MemtoReg_in), .Lower_in(Lower_in), .Higher_in(Higher_in),
        .BEn_in(BEn_in), .Br_in(Br_in), .PCS_in(PCS_in), .wreg_in(wreg_in),
        .npc_in(npc_in), .a_in(a_in), .b_in(b_in), .imm_in(imm_in),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .exmem_fwd(exmem_fwd), .memwb_fwd(memwb_fwd),
        .br_taken(br_taken), .br_target(br_target), .flags_out(flags_out),
        .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .MemtoReg_out(MemtoReg_out), .valid_out(valid_out), .wreg_out(wreg_out),
        .result_out(result_out), .store_out(store_out)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic clear_inputs();
        rst = 1'b0; en = 1'b1; flush = 1'b0; valid_in = 1'b0;
        opcode_in = 4'h0; ccc_in = 3'b000;
        RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; MemtoReg_in = 1'b0;
        Lower_in = 1'b0; Higher_in = 1'b0; BEn_in = 1'b0; Br_in = 1'b0; PCS_in = 1'b0;
        wreg_in = 4'h0; npc_in = 16'h0; a_in = 16'h0; b_in = 16'h0; imm_in = 16'h0;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; exmem_fwd = 16'h0; memwb_fwd = 16'h0;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] imm);
        clear_inputs();
        valid_in = 1'b1; RegWrite_in = 1'b1; wreg_in = 4'h3;
        opcode_in = op; a_in = a; b_in = b; imm_in = imm;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++; if (result_out !== 16'h0) begin errors++; $display("FAIL reset_result got=%h exp=0000", result_out); end
        checks++; if (flags_out !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", flags_out); end
        checks++; if ({valid_out, RegWrite_out, wreg_out} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", {valid_out, RegWrite_out, wreg_out}); end
        rst = 1'b0;
    endtask

    task automatic test_add_sat();
        drive_alu(4'h0, 16'h7FFF, 16'h0001, 16'h0);
        tick();
        checks++; if (result_out !== 16'h7FFF) begin errors++; $display("FAIL add_pos_sat got=%h exp=7fff", result_out); end
        checks++; if (flags_out !== 3'b010) begin errors++; $display("FAIL add_pos_flags got=%b exp=010", flags_out); end
        checks++; if ({valid_out, RegWrite_out, wreg_out} !== 6'b11_0011) begin errors++; $display("FAIL add_ctrl got=%b exp=110011", {valid_out, RegWrite_out, wreg_out}); end
        drive_alu(4'h0, 16'h8000, 16'hFFFF, 16'h0);
        tick();
        checks++; if (result_out !== 16'h8000) begin errors++; $display("FAIL add_neg_sat got=%h exp=8000", result_out); end
        checks++; if (flags_out !== 3'b011) begin errors++; $display("FAIL add_neg_flags got=%b exp=011", flags_out); end
    endtask

    task automatic test_xor_zonly();
        // flags are 011 from the previous ADD; XOR writes only Z
        drive_alu(4'h2, 16'h00FF, 16'h00FF, 16'h0);
        tick();
        checks++; if (result_out !== 16'h0000) begin errors++; $display("FAIL xor_result got=%h exp=0000", result_out); end
        checks++; if (flags_out !== 3'b111) begin errors++; $display("FAIL xor_flags got=%b exp=111", flags_out); end
    endtask

    task automatic test_sub_branch();
        drive_alu(4'h1, 16'h0005, 16'h0005, 16'h0);
        tick();
        checks++; if (result_out !== 16'h0000) begin errors++; $display("FAIL sub_result got=%h exp=0000", result_out); end
        checks++; if (flags_out !== 3'b100) begin errors++; $display("FAIL sub_flags got=%b exp=100", flags_out); end
        clear_inputs();
        valid_in = 1'b1; opcode_in = 4'hC; BEn_in = 1'b1; ccc_in = 3'b001;
        npc_in = 16'h0010; imm_in = 16'h0004;
        #1;
        checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_eq_taken got=%b exp=1", br_taken); end
        checks++; if (br_target !== 16'h0018) begin errors++; $display("FAIL br_target got=%h exp=0018", br_target); end
        ccc_in = 3'b000; #1;
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_ne_not_taken got=%b exp=0", br_taken); end
        ccc_in = 3'b111; valid_in = 1'b0; #1;
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_invalid got=%b exp=0", br_taken); end
        valid_in = 1'b1; Br_in = 1'b1; fwd_a_sel = 2'b10; memwb_fwd = 16'h4444; #1;
        checks++; if (br_target !== 16'h4444) begin errors++; $display("FAIL br_reg_target got=%h exp=4444", br_target); end
        imm_in = 16'hFFFE; Br_in = 1'b0; #1;
        checks++; if (br_target !== 16'h000C) begin errors++; $display("FAIL br_neg_target got=%h exp=000c", br_target); end
        tick();
        checks++; if (result_out !== 16'h0000 || flags_out !== 3'b100) begin errors++; $display("FAIL br_result got=%h/%b exp=0000/100", result_out, flags_out); end
    endtask

    task automatic test_paddsb();
        drive_alu(4'h7, 16'h7181, 16'h1181, 16'h0);
        tick();
        checks++; if (result_out !== 16'h7282) begin errors++; $display("FAIL paddsb got=%h exp=7282", result_out); end
        checks++; if (flags_out !== 3'b100) begin errors++; $display("FAIL paddsb_flags got=%b exp=100", flags_out); end
    endtask

    task automatic test_red();
        drive_alu(4'h3, 16'h7F01, 16'h7F01, 16'h0);
        tick();
        checks++; if (result_out !== 16'h0100) begin errors++; $display("FAIL red_pos got=%h exp=0100", result_out); end
        drive_alu(4'h3, 16'h8080, 16'h8080, 16'h0);
        tick();
        checks++; if (result_out !== 16'hFE00) begin errors++; $display("FAIL red_neg got=%h exp=fe00", result_out); end
    endtask

    task automatic test_shifts();
        drive_alu(4'h4, 16'h0001, 16'h0, 16'h0004);
        tick();
        checks++; if (result_out !== 16'h0010) begin errors++; $display("FAIL sll got=%h exp=0010", result_out); end
        drive_alu(4'h5, 16'h8000, 16'h0, 16'h0003);
        tick();
        checks++; if (result_out !== 16'hF000) begin errors++; $display("FAIL sra got=%h exp=f000", result_out); end
        drive_alu(4'h6, 16'h0001, 16'h0, 16'h0001);
        tick();
        checks++; if (result_out !== 16'h8000) begin errors++; $display("FAIL ror got=%h exp=8000", result_out); end
        drive_alu(4'h6, 16'h1234, 16'h0, 16'h0000);
        tick();
        checks++; if (result_out !== 16'h1234) begin errors++; $display("FAIL ror_zero got=%h exp=1234", result_out); end
        checks++; if (flags_out !== 3'b000) begin errors++; $display("FAIL ror_flags got=%b exp=000", flags_out); end
    endtask

    task automatic test_mem();
        drive_alu(4'h8, 16'h1001, 16'h0, 16'hFFFE);
        MemRead_in = 1'b1; MemtoReg_in = 1'b1; fwd_a_sel = 2'b01; exmem_fwd = 16'h2001;
        tick();
        checks++; if (result_out !== 16'h1FFC) begin errors++; $display("FAIL lw_addr got=%h exp=1ffc", result_out); end
        checks++; if ({MemRead_out, MemtoReg_out, MemWrite_out} !== 3'b110) begin errors++; $display("FAIL lw_ctrl got=%b exp=110", {MemRead_out, MemtoReg_out, MemWrite_out}); end
        drive_alu(4'h9, 16'h0100, 16'h1111, 16'h0002);
        RegWrite_in = 1'b0; MemWrite_in = 1'b1; fwd_b_sel = 2'b10; memwb_fwd = 16'hBEEF;
        tick();
        checks++; if (result_out !== 16'h0104 || store_out !== 16'hBEEF) begin errors++; $display("FAIL sw got=%h/%h exp=0104/beef", result_out, store_out); end
        checks++; if ({MemWrite_out, RegWrite_out} !== 2'b10) begin errors++; $display("FAIL sw_ctrl got=%b exp=10", {MemWrite_out, RegWrite_out}); end
    endtask

    task automatic test_llb_lhb_pcs();
        drive_alu(4'hA, 16'h1234, 16'h0, 16'h00AB);
        Lower_in = 1'b1;
        tick();
        checks++; if (result_out !== 16'h12AB) begin errors++; $display("FAIL llb got=%h exp=12ab", result_out); end
        drive_alu(4'hB, 16'h1234, 16'h0, 16'hFFAB);
        Higher_in = 1'b1;
        tick();
        checks++; if (result_out !== 16'hAB34) begin errors++; $display("FAIL lhb got=%h exp=ab34", result_out); end
        drive_alu(4'hE, 16'h1234, 16'h5678, 16'h0);
        PCS_in = 1'b1; npc_in = 16'h0042;
        tick();
        checks++; if (result_out !== 16'h0042) begin errors++; $display("FAIL pcs got=%h exp=0042", result_out); end
    endtask

    task automatic test_stall_flush();
        drive_alu(4'h1, 16'h0003, 16'h0005, 16'h0);  // 3-5 = FFFE, flags 001
        MemWrite_in = 1'b1;
        tick();
        checks++; if (result_out !== 16'hFFFE || flags_out !== 3'b001) begin errors++; $display("FAIL stall_setup got=%h/%b exp=fffe/001", result_out, flags_out); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in = 16'h1000 + 16'(i); b_in = 16'h1000 - 16'(i); opcode_in = 4'h0; fwd_a_sel = 2'b01; exmem_fwd = 16'h7000;
            tick();
            checks++; if (result_out !== 16'hFFFE || flags_out !== 3'b001 || valid_out !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got=%h/%b/%b exp=fffe/001/1", i, result_out, flags_out, valid_out); end
        end
        en = 1'b1; flush = 1'b1;
        tick();
        checks++; if ({RegWrite_out, MemWrite_out, valid_out} !== 3'b000) begin errors++; $display("FAIL flush_ctrl got=%b exp=000", {RegWrite_out, MemWrite_out, valid_out}); end
        checks++; if (flags_out !== 3'b001) begin errors++; $display("FAIL flush_flags got=%b exp=001", flags_out); end
    endtask

    task automatic test_back_to_back();
        drive_alu(4'h0, 16'h0100, 16'h0023, 16'h0);
        tick();
        checks++; if (result_out !== 16'h0123 || flags_out !== 3'b000) begin errors++; $display("FAIL b2b_add got=%h/%b exp=0123/000", result_out, flags_out); end
        drive_alu(4'h1, 16'h8000, 16'h0001, 16'h0);
        tick();
        checks++; if (result_out !== 16'h8000 || flags_out !== 3'b011) begin errors++; $display("FAIL b2b_sub got=%h/%b exp=8000/011", result_out, flags_out); end
    endtask

    task automatic test_mid_reset();
        drive_alu(4'h0, 16'h0001, 16'h0001, 16'h0);
        tick();
        BEn_in = 1'b1; ccc_in = 3'b111; rst = 1'b1;
        #1;
        checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL rst_br_taken got=%b exp=0", br_taken); end
        tick();
        checks++; if (result_out !== 16'h0 || flags_out !== 3'b000 || valid_out !== 1'b0 || RegWrite_out !== 1'b0) begin errors++; $display("FAIL mid_reset got=%h/%b/%b/%b exp=0000/000/0/0", result_out, flags_out, valid_out, RegWrite_out); end
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_add_sat();
        test_xor_zonly();
        test_sub_branch();
        test_paddsb();
        test_red();
        test_shifts();
        test_mem();
        test_llb_lhb_pcs();
        test_stall_flush();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
